fa_serial_ctrl: RTL and testbench
=================================

Name: fa_serial_ctrl

Overview:
- Bit-serial adder controller. It sequences the team's existing 1-bit full adder cell, fa (ports a, b, ci, s, co), over a WIDTH-bit operand pair, one bit per clock, LSB first.
- A start/done handshake accepts one operation at a time.
- The block is the sequential wrapper that turns the single combinational fa cell into a multi-bit adder for the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled on the rising edge.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- ci  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while the operation is in the RUN state.
- done  output  1  one-cycle pulse; result is valid.
- s  output  WIDTH  sum result register.
- co  output  1  final carry-out register.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - state=IDLE.
  - busy=0, done=0, s=0, co=0.
  - Internal shift registers, carry register and bit counter all cleared.
- States: IDLE, RUN, DONE. State is held in a registered state register.
- IDLE:
  - If start=1 at a clock edge, the block accepts the request:
    - a_sh<=a, b_sh<=b, carry<=ci, cnt<=0, state<=RUN.
  - If start=0, the block stays in IDLE.
- RUN (busy=1):
  - The fa instance is driven combinationally with a_sh[0], b_sh[0] and carry.
  - Each edge does the following:
    - a_sh and b_sh shift right by 1.
    - The fa sum is shifted into sum_sh at the MSB, so sum_sh ends LSB-aligned.
    - carry<=fa co.
    - cnt<=cnt+1.
  - When cnt==WIDTH-1, the edge performs the final shift and also:
    - s<=final sum_sh.
    - co<=final fa co.
    - state<=DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then state<=IDLE unconditionally.
- Latency: with the accepting edge at cycle 0, RUN occupies cycles 1..WIDTH and done is high in cycle WIDTH+1.
  - Example: WIDTH=8 gives done in the 9th cycle after the accept edge.
  - WIDTH=1 gives exactly one RUN cycle.
- Throughput: the earliest next accept is the edge that ends the IDLE cycle following DONE.
- Result holding: s and co change only on the RUN->DONE edge. They hold their previous result during RUN and hold the new result in IDLE until the next operation completes.
- Counter width: the counter is max(1,$clog2(WIDTH)) bits wide and never wraps in normal operation.
- start during RUN or DONE: ignored; no queuing and no restart. Operands a, b and ci may change freely after acceptance.
- start held high continuously: one operation per WIDTH+2 cycles (IDLE accept, WIDTH RUN cycles, DONE).
- Reset mid-operation: the operation is aborted immediately (asynchronous), all outputs go to their reset values, and no done pulse is produced.
- Arithmetic: {co,s} = a + b + ci, modulo 2^(WIDTH+1). No overflow flag in the base build.

Optional Feature:
- Macro: FA_SERIAL_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), captured together with the operands at accept.
  - If sub=1, b_sh is loaded with ~b and carry is loaded with 1, overriding ci. The block therefore computes a - b in two's complement; co=1 means no borrow (a >= b unsigned).
  - If sub=0, behaviour is identical to the base build.
  - Latency and handshake are unchanged.
- When not defined: there is no sub port, and the logic is exactly the base build.

Test Plan:
- Reset, then start with a=0x00, b=0x00, ci=0 (WIDTH=8) -> busy high for 8 cycles; done pulses in cycle 9; s=0x00, co=0.
- a=0xFF, b=0x01, ci=0 -> s=0x00, co=1. Then a=0x3C, b=0x0F, ci=0 -> s=0x4B, co=0, and the previous s/co hold (0x00/1) during RUN.
- a=0xA5, b=0x5A, ci=1 -> s=0x00, co=1. With start held high throughout, exactly one done per 10 cycles and every result is correct.
- Start a=0x12, b=0x34, then pulse start again at RUN cycle 3 with a=0xFF -> the second pulse is ignored; result s=0x46, co=0.
- Assert reset_n low at RUN cycle 4 of any operation -> busy, done, s and co are 0 immediately; no done pulse; the next start completes normally.
- With FA_SERIAL_SUB_EN: a=0x10, b=0x01, sub=1 -> s=0x0F, co=1. Then a=0x01, b=0x02, sub=1 -> s=0xFF, co=0.

Source files
------------

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder: sequences one fa cell over WIDTH bits, LSB first, with start/done handshake.
// Optional subtract mode via `define FA_SERIAL_SUB_EN (adds input port sub).

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module fa_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef FA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next, b_load;
  logic             carry, ci_load, fa_s, fa_co, last_bit;
  logic [CW-1:0]    cnt;

`ifdef FA_SERIAL_SUB_EN
  assign b_load  = sub ? ~b : b;
  assign ci_load = sub ? 1'b1 : ci;
`else
  assign b_load  = b;
  assign ci_load = ci;
`endif

  fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB so the result is LSB-aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_sum1
      assign sum_next = fa_s;
    end else begin : g_sumn
      assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      co     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b_load;
          carry <= ci_load;
          cnt   <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_co;
          if (last_bit) begin
            s  <= sum_next;
            co <= fa_co;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Directed self-checking bench for fa_serial_ctrl (WIDTH=8).

module tb_fa_serial_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             ci;
  logic             busy, done, co;
  logic [WIDTH-1:0] s;
`ifdef FA_SERIAL_SUB_EN
  logic             sub;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fa_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ci      (ci),
`ifdef FA_SERIAL_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .s       (s),
    .co      (co)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation from IDLE and follows it to the done pulse (bounded).
  // Leaves the bench sampling inside the DONE cycle when done is seen.
  task automatic run_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ici, output int nbusy, output int done_at,
                        output logic hold_ok);
    logic [WIDTH-1:0] s0;
    logic             c0;
    s0 = s; c0 = co; hold_ok = 1'b1;
    a = ia; b = ib; ci = ici; start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0; done_at = -1;
    for (int k = 1; k <= int'(WIDTH) + 5; k++) begin
      if (busy) nbusy++;
      if (busy && (s !== s0 || co !== c0)) hold_ok = 1'b0;
      if (done) begin
        done_at = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef FA_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_s: got %h want 00", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b want 0", co); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int nb, da; logic h;
    run_op(8'h00, 8'h00, 1'b0, nb, da, h);
    checks++; if (nb !== 8) begin errors++; $display("FAIL zero_busy_cycles: got %0d want 8", nb); end
    checks++; if (da !== 9) begin errors++; $display("FAIL zero_done_cycle: got %0d want 9", da); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL zero_s: got %h want 00", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL zero_co: got %b want 0", co); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_in_done: got %b want 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", done); end
  endtask

  task automatic test_carry();
    int nb, da; logic h;
    run_op(8'hFF, 8'h01, 1'b0, nb, da, h);
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL ff01_s: got %h want 00", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL ff01_co: got %b want 1", co); end
    tick();
    run_op(8'h3C, 8'h0F, 1'b0, nb, da, h);
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL hold_prev_result: got %b want 1", h); end
    checks++; if (s !== 8'h4B) begin errors++; $display("FAIL 3c0f_s: got %h want 4b", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL 3c0f_co: got %b want 0", co); end
    tick();
  endtask

  task automatic test_back_to_back();
    int ndone, last_at, gap;
    ndone = 0; last_at = -1; gap = 0;
    a = 8'hA5; b = 8'h5A; ci = 1'b1; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) begin
        ndone++;
        if (last_at >= 0) gap = k - last_at;
        last_at = k;
        checks++; if (s !== 8'h00) begin errors++; $display("FAIL b2b_s: got %h want 00", s); end
        checks++; if (co !== 1'b1) begin errors++; $display("FAIL b2b_co: got %b want 1", co); end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", ndone); end
    checks++; if (gap !== 10) begin errors++; $display("FAIL b2b_period: got %0d want 10", gap); end
    checks++; if (last_at !== 29) begin errors++; $display("FAIL b2b_last_done: got %0d want 29", last_at); end
    while (busy || done) tick();
    tick();
  endtask

  task automatic test_ignore_start();
    int da, nd;
    a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    da = -1; nd = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin start = 1'b1; a = 8'hFF; end
      if (k == 4) start = 1'b0;
      if (done) begin
        nd++;
        if (da < 0) begin
          da = k;
          checks++; if (s !== 8'h46) begin errors++; $display("FAIL ignore_s: got %h want 46", s); end
          checks++; if (co !== 1'b0) begin errors++; $display("FAIL ignore_co: got %b want 0", co); end
        end
      end
      tick();
    end
    checks++; if (da !== 9) begin errors++; $display("FAIL ignore_done_cycle: got %0d want 9", da); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
  endtask

  task automatic test_reset_mid();
    int nd, nb, da; logic h;
    a = 8'h11; b = 8'h22; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL midrst_s: got %h want 00", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL midrst_co: got %b want 0", co); end
    tick();
    reset_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) nd++;
      tick();
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_activity: got %0d want 0", nd); end
    run_op(8'h55, 8'h0A, 1'b0, nb, da, h);
    checks++; if (da !== 9) begin errors++; $display("FAIL postrst_done_cycle: got %0d want 9", da); end
    checks++; if (s !== 8'h5F) begin errors++; $display("FAIL postrst_s: got %h want 5f", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL postrst_co: got %b want 0", co); end
    tick();
  endtask

`ifdef FA_SERIAL_SUB_EN
  task automatic test_sub();
    int nb, da; logic h;
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, nb, da, h);
    checks++; if (s !== 8'h0F) begin errors++; $display("FAIL sub1_s: got %h want 0f", s); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL sub1_co: got %b want 1", co); end
    tick();
    run_op(8'h01, 8'h02, 1'b0, nb, da, h);
    checks++; if (s !== 8'hFF) begin errors++; $display("FAIL sub2_s: got %h want ff", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL sub2_co: got %b want 0", co); end
    tick();
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
`ifdef FA_SERIAL_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
